// File: rtl/global_ram_writeback_pkg.sv
// global_ram_writeback_pkg: shared drain-FSM state type and default sizing constants.
// Revision 1.0
`default_nettype none

package global_ram_writeback_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } wb_state_t;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

endpackage

`default_nettype wire

// File: rtl/global_ram_writeback_wb_fifo.sv
// wb_fifo: pointer-based write-back queue storage; entries are valid by pointer distance only.
// Revision 1.0
`default_nettype none

module wb_fifo
  import global_ram_writeback_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       push_is_word,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic                       head_is_word,
  output logic [ADDR_W-1:0]          head_addr,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [ADDR_W-1:0]          mem_addr [DEPTH],
  output logic [DATA_W-1:0]          mem_data [DEPTH],
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              word_mem [DEPTH];

  // Storage carries no reset; only the pointers decide which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
      word_mem[wr_ptr] <= push_is_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_is_word = word_mem[rd_ptr];
  assign head_addr    = addr_mem[rd_ptr];
  assign head_data    = data_mem[rd_ptr];
  assign mem_addr     = addr_mem;
  assign mem_data     = data_mem;
  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);

endmodule

`default_nettype wire

// File: rtl/global_ram_writeback.sv
// global_ram_writeback: cache-to-global-RAM write-back queue with drain FSM, flush and read forwarding.
// Revision 1.0
`default_nettype none

module global_ram_writeback
  import global_ram_writeback_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_is_word,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     ram_req,
  input  logic                     ram_ack,
  output logic                     ram_is_word,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_data,
  input  logic                     flush,
  output logic                     flush_done,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     lookup_hit,
  output logic [DATA_W-1:0]        lookup_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_state_t         state_q, state_d;
  logic              flush_active;
  logic              push, pop;
  logic [DATA_W-1:0] push_data;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  lk_idx;
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  // Gating with rst_n keeps in_ready low while reset is held.
  assign in_ready  = rst_n && !full && !flush_active;
  assign push      = in_valid && in_ready;
  assign push_data = in_is_word ? in_data : {{(DATA_W-1){1'b0}}, in_data[0]};

  wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .push_is_word (in_is_word),
    .push_addr    (in_addr),
    .push_data    (push_data),
    .pop          (pop),
    .head_is_word (ram_is_word),
    .head_addr    (ram_addr),
    .head_data    (ram_data),
    .rd_ptr       (rd_ptr),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ram_req = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (count != '0) state_d = REQ;
      REQ: begin
        ram_req = 1'b1;
        if (ram_ack) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_active <= 1'b0;
      flush_done   <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      if ((flush_active || flush) && empty && (state_q == IDLE)) begin
        flush_active <= 1'b0;
        flush_done   <= 1'b1;
      end else if (flush) begin
        flush_active <= 1'b1;
      end
    end
  end

  // Walk oldest to newest so the last match seen is the newest entry.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lk_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (mem_addr[lk_idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = mem_data[lk_idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_global_ram_writeback.sv
// tb_global_ram_writeback: directed self-checking bench for the write-back queue.
// Revision 1.0
`default_nettype none

module tb_global_ram_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_is_word;
  logic [15:0] in_addr;
  logic [7:0]  in_data;
  logic        ram_req, ram_ack, ram_is_word;
  logic [15:0] ram_addr;
  logic [7:0]  ram_data;
  logic        flush, flush_done;
  logic [15:0] lookup_addr;
  logic        lookup_hit;
  logic [7:0]  lookup_data;
  logic [3:0]  count;
  logic        full, empty;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  global_ram_writeback #(.DEPTH(8), .ADDR_W(16), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_is_word  (in_is_word),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .ram_req     (ram_req),
    .ram_ack     (ram_ack),
    .ram_is_word (ram_is_word),
    .ram_addr    (ram_addr),
    .ram_data    (ram_data),
    .flush       (flush),
    .flush_done  (flush_done),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [15:0] a, input logic [7:0] d);
    in_valid   = v;
    in_is_word = w;
    in_addr    = a;
    in_data    = d;
  endtask

  initial begin
    rst_n = 1'b0; ram_ack = 1'b0; flush = 1'b0; lookup_addr = 16'h0000;
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    #1;
    check("rst_ram_req", ram_req, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_hit", lookup_hit, 0);
    check("rst_flush_done", flush_done, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("idle_in_ready", in_ready, 1);

    // Word write with ack held high
    ram_ack = 1'b1;
    drive(1'b1, 1'b1, 16'h0010, 8'hA5);
    step();
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    check("w_count_after_push", count, 1);
    check("w_req_not_yet", ram_req, 0);
    step();
    check("w_req", ram_req, 1);
    check("w_addr", ram_addr, 16'h0010);
    check("w_data", ram_data, 8'hA5);
    check("w_is_word", ram_is_word, 1);
    step();
    check("w_req_drop", ram_req, 0);
    check("w_empty", empty, 1);
    ram_ack = 1'b0;

    // Bit write
    drive(1'b1, 1'b0, 16'h0003, 8'hFF);
    step();
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    step();
    check("b_req", ram_req, 1);
    check("b_data", ram_data, 8'h01);
    check("b_is_word", ram_is_word, 0);
    step();
    check("b_req_hold", ram_req, 1);
    check("b_addr_hold", ram_addr, 16'h0003);
    ram_ack = 1'b1;
    step();
    check("b_empty", empty, 1);
    ram_ack = 1'b0;

    // Fill to full, reject 9th, drain in order
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 16'h0100 + 16'(i), 8'h30 + 8'(i));
      step();
    end
    check("f_full", full, 1);
    check("f_in_ready", in_ready, 0);
    check("f_count", count, 8);
    drive(1'b1, 1'b1, 16'h01FF, 8'hEE);
    step();
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    check("f_9th_rejected", count, 8);
    ram_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("d_req", ram_req, 1);
      check("d_addr", ram_addr, 16'h0100 + 16'(i));
      check("d_data", ram_data, 8'h30 + 8'(i));
      step();
      check("d_gap", ram_req, 0);
      check("d_count", count, 7 - i);
      step();
    end
    check("d_empty", empty, 1);
    check("d_no_req", ram_req, 0);
    ram_ack = 1'b0;

    // Forwarding returns newest match
    drive(1'b1, 1'b1, 16'h0020, 8'h11);
    step();
    drive(1'b1, 1'b1, 16'h0020, 8'h22);
    step();
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    lookup_addr = 16'h0020;
    #1;
    check("lk_hit", lookup_hit, 1);
    check("lk_data", lookup_data, 8'h22);
    lookup_addr = 16'h0021;
    #1;
    check("lk_miss_hit", lookup_hit, 0);
    check("lk_miss_data", lookup_data, 8'h00);
    lookup_addr = 16'h0020;
    ram_ack = 1'b1;
    step();
    check("lk_after_pop_hit", lookup_hit, 1);
    check("lk_after_pop_data", lookup_data, 8'h22);
    step(); step();
    check("lk_drained", empty, 1);
    check("lk_gone", lookup_hit, 0);
    ram_ack = 1'b0;

    // Flush with 3 entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 16'h0040 + 16'(i), 8'h50 + 8'(i));
      step();
    end
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_in_ready", in_ready, 0);
    check("fl_done_early", flush_done, 0);
    drive(1'b1, 1'b1, 16'h0077, 8'h77);
    step();
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    check("fl_push_blocked", count, 3);
    ram_ack = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("fl_done", flush_done, (k == 6) ? 1 : 0);
      check("fl_ready", in_ready, (k >= 6) ? 1 : 0);
    end
    ram_ack = 1'b0;

    // Flush while already empty and idle
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fe_done", flush_done, 1);
    step();
    check("fe_done_clear", flush_done, 0);

    // Reset mid-request with 4 entries queued
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 16'h0060 + 16'(i), 8'h60 + 8'(i));
      step();
    end
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    check("r_req_before", ram_req, 1);
    check("r_count_before", count, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_req_drop", ram_req, 0);
    check("r_count", count, 0);
    check("r_empty", empty, 1);
    check("r_in_ready", in_ready, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("r_no_req", ram_req, 0);
    end
    drive(1'b1, 1'b1, 16'h0099, 8'h5A);
    step();
    drive(1'b0, 1'b0, 16'h0, 8'h0);
    step();
    check("r_new_req", ram_req, 1);
    check("r_new_addr", ram_addr, 16'h0099);
    check("r_new_data", ram_data, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/global_ram_writeback.md
GLOBAL_RAM_WRITEBACK -- requirements
Module: global_ram_writeback

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, as the number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 The module SHALL have parameter ADDR_W, default 16, as the global RAM address width.
REQ-003 The module SHALL have parameter DATA_W, default 8, as the word data width.
REQ-004 Port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port in_valid, input, 1 bit: the cache offers a write entry.
REQ-007 Port in_ready, output, 1 bit: the queue accepts the entry this cycle.
REQ-008 Port in_is_word, input, 1 bit: 1 selects a word write; 0 selects a bit write, with the bit carried in in_data[0].
REQ-009 Port in_addr, input, ADDR_W bits: target global RAM address.
REQ-010 Port in_data, input, DATA_W bits: write data.
REQ-011 Port ram_req, output, 1 bit: write request to global RAM.
REQ-012 Port ram_ack, input, 1 bit: global RAM has completed the current write.
REQ-013 Ports ram_is_word (1 bit), ram_addr (ADDR_W bits) and ram_data (DATA_W bits), outputs: the head entry's fields.
REQ-014 Port flush, input, 1 bit: request to drain all entries.
REQ-015 Port flush_done, output, 1 bit: one-cycle pulse when a flush completes.
REQ-016 Port lookup_addr, input, ADDR_W bits: address probed by the cache read path.
REQ-017 Ports lookup_hit (1 bit) and lookup_data (DATA_W bits), outputs: forwarding result for lookup_addr.
REQ-018 Ports count ($clog2(DEPTH)+1 bits), full (1 bit) and empty (1 bit), outputs: queue occupancy status.

Function
REQ-019 An entry SHALL be written into the queue on any rising edge where in_valid and in_ready are both 1.
REQ-020 in_ready SHALL equal (!full && !flush_active).
REQ-021 The queue SHALL be FIFO; write and read pointers wrap modulo DEPTH; count SHALL range from 0 to DEPTH.
REQ-022 The drain FSM SHALL have two states, IDLE and REQ.
- IDLE -> REQ when count != 0.
- REQ -> IDLE on ram_ack.
REQ-023 ram_req SHALL be 1 exactly in state REQ; ram_addr, ram_data and ram_is_word SHALL hold the head entry and remain stable while ram_req is 1.
REQ-024 On ram_ack in state REQ, the head entry SHALL pop at that edge; ram_ack in IDLE SHALL be ignored.
REQ-025 Latency: an entry pushed into an empty queue at edge N SHALL show ram_req=1 after edge N+1; back-to-back drains SHALL use 2 cycles per entry minimum (REQ followed by IDLE).
REQ-026 A push and a pop on the same edge SHALL leave count unchanged; a push while full is impossible because in_ready=0; there is no bypass path.
REQ-027 For a bit entry, ram_data SHALL be {DATA_W-1 zeros, in_data[0]}.
REQ-028 lookup_hit SHALL be combinational and SHALL be 1 when any valid entry's address equals lookup_addr.
REQ-029 lookup_data SHALL come from the newest matching entry, or 0 when there is no hit.
REQ-030 flush=1 SHALL set flush_active.
REQ-031 flush_active SHALL clear, and flush_done SHALL pulse, on the first edge at which the queue is empty with the FSM in IDLE.
REQ-032 flush asserted while already empty and IDLE SHALL pulse flush_done on the next edge.

Reset
REQ-033 rst_n=0 SHALL asynchronously clear the pointers, count, flush_active and the FSM state (to IDLE), discarding all entries.
REQ-034 During reset, outputs SHALL be: ram_req=0, flush_done=0, in_ready=0, lookup_hit=0, empty=1, full=0, count=0.
REQ-035 Reset asserted while ram_req=1 SHALL drop ram_req immediately, without waiting for ram_ack.
REQ-036 Entry storage SHALL NOT require reset; validity SHALL derive from the pointers only.

Structure
REQ-037 A shared package SHALL hold the FSM state enum (IDLE, REQ) and the default constants DEPTH=8, ADDR_W=16, DATA_W=8.
REQ-038 Storage plus pointers SHALL form one sub-module, wb_fifo; the FSM, flush and lookup logic SHALL stay in the top module.

Verification
REQ-039 Push word (0x0010, 0xA5), ram_ack held 1 -> ram_req=1 with addr 0x0010, data 0xA5, is_word=1 one cycle after the push; empty=1 after the ack.
REQ-040 Push 8 entries, ram_ack=0 -> full=1, in_ready=0, count=8; a 9th push is not accepted; release ram_ack -> the entries drain in order.
REQ-041 Push bit (0x0003, in_data=0xFF) -> ram_data=0x01, ram_is_word=0.
REQ-042 Push (0x0020, 0x11) then (0x0020, 0x22), probe 0x0020 -> hit=1, data=0x22; probe 0x0021 -> hit=0, data=0x00.
REQ-043 With 3 entries queued, assert flush -> in_ready=0 until drained; exactly one flush_done pulse after the 3rd ack.
REQ-044 Assert rst_n=0 mid-REQ with 4 entries queued -> ram_req=0 immediately; count=0 and empty=1; no further ram_req after release until a new push.
